// File: rtl/fft_pkg.sv
// Shared state type and elaboration-time helpers for the streaming radix-2 FFT core:
// bit reversal, rounded twiddle generation and saturation.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} fft_state_e;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } tw_t;

  localparam int DEF_POINTS = 8;
  localparam int DEF_LOG2N  = $clog2(DEF_POINTS);

  function automatic int bitrev(input int idx, input int log2n);
    int r;
    r = 0;
    for (int i = 0; i < log2n; i++) r |= ((idx >> i) & 1) << (log2n - 1 - i);
    return r;
  endfunction

  // Forward twiddles are exp(-j*2*pi*t/points), inverse ones the conjugate.
  // +1.0 is not representable in Q1.(tw_w-1) and clamps to the largest positive code.
  function automatic tw_t twiddle(input int t, input int points, input logic inverse, input int tw_w);
    real    ang, scale, s;
    longint lim, vr, vi;
    tw_t    w;
    ang   = 2.0 * 3.14159265358979323846 * real'(t) / real'(points);
    scale = real'(64'(1) << (tw_w - 1));
    lim   = (longint'(1) << (tw_w - 1)) - 1;
    s     = $sin(ang) * scale;
    vr    = longint'($cos(ang) * scale);
    vi    = inverse ? longint'(s) : longint'(-s);
    if (vr > lim) vr = lim;
    if (vi > lim) vi = lim;
    w.re = 32'(vr);
    w.im = 32'(vi);
    return w;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fft_radix2_bfly.sv
// Combinational radix-2 DIT butterfly: rounded complex multiply b*W, add/sub against a,
// optional floor-halving for inverse frames, saturation with a clip flag.
module fft_radix2_bfly
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic signed [DATA_W-1:0] i_a_re,
  input  logic signed [DATA_W-1:0] i_a_im,
  input  logic signed [DATA_W-1:0] i_b_re,
  input  logic signed [DATA_W-1:0] i_b_im,
  input  logic signed [TW_W-1:0]   i_w_re,
  input  logic signed [TW_W-1:0]   i_w_im,
  input  logic                     i_inverse,
  output logic signed [DATA_W-1:0] o_a_re,
  output logic signed [DATA_W-1:0] o_a_im,
  output logic signed [DATA_W-1:0] o_b_re,
  output logic signed [DATA_W-1:0] o_b_im,
  output logic                     o_clip
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam int SW = DATA_W + 2;

  logic signed [PW-1:0] w_prod_re, w_prod_im, w_rnd_re, w_rnd_im;
  logic signed [SW-1:0] w_p_re, w_p_im;
  logic signed [SW-1:0] w_sum [4];
  logic signed [SW-1:0] w_pre [4];
  logic signed [31:0]   w_sat [4];
  logic [3:0]           w_clip;

  assign w_prod_re = PW'(i_b_re) * PW'(i_w_re) - PW'(i_b_im) * PW'(i_w_im);
  assign w_prod_im = PW'(i_b_re) * PW'(i_w_im) + PW'(i_b_im) * PW'(i_w_re);
  assign w_rnd_re  = w_prod_re + (PW'(1) <<< (TW_W - 2));
  assign w_rnd_im  = w_prod_im + (PW'(1) <<< (TW_W - 2));
  assign w_p_re    = SW'(w_rnd_re >>> (TW_W - 1));
  assign w_p_im    = SW'(w_rnd_im >>> (TW_W - 1));

  assign w_sum[0] = SW'(i_a_re) + w_p_re;
  assign w_sum[1] = SW'(i_a_im) + w_p_im;
  assign w_sum[2] = SW'(i_a_re) - w_p_re;
  assign w_sum[3] = SW'(i_a_im) - w_p_im;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign w_pre[gi]  = i_inverse ? (w_sum[gi] >>> 1) : w_sum[gi];
    assign w_sat[gi]  = saturate(32'(w_pre[gi]), DATA_W);
    assign w_clip[gi] = (w_sat[gi] != 32'(w_pre[gi]));
  end

  assign o_a_re = w_sat[0][DATA_W-1:0];
  assign o_a_im = w_sat[1][DATA_W-1:0];
  assign o_b_re = w_sat[2][DATA_W-1:0];
  assign o_b_im = w_sat[3][DATA_W-1:0];
  assign o_clip = |w_clip;

endmodule

// File: rtl/fft8_stream_core.sv
// Streaming in-place radix-2 DIT FFT/IFFT: loads a frame in bit-reversed order,
// runs one butterfly per cycle over a register array, then streams bins in natural order.
module fft8_stream_core
  import fft_pkg::*;
#(
  parameter int POINTS = 8,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_re,
  input  logic signed [DATA_W-1:0] s_im,
  input  logic                     inverse,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_re,
  output logic signed [DATA_W-1:0] m_im,
  output logic                     m_last,
  output logic                     busy,
  output logic                     ovf
);

  localparam int LOG2N = $clog2(POINTS);
  localparam int STW   = $clog2(LOG2N + 1);
  localparam int BFW   = LOG2N - 1;

  fft_state_e               r_state;
  logic [LOG2N-1:0]         r_cnt;
  logic [STW-1:0]           r_stage;
  logic [BFW-1:0]           r_bf;
  logic                     r_mode, r_ovf, r_m_valid, r_m_last;
  logic signed [DATA_W-1:0] r_m_re, r_m_im;
  logic signed [DATA_W-1:0] r_mem_re [POINTS];
  logic signed [DATA_W-1:0] r_mem_im [POINTS];
  logic signed [TW_W-1:0]   w_rom_re [POINTS];
  logic signed [TW_W-1:0]   w_rom_im [POINTS];

  logic [LOG2N-1:0]         w_j, w_mask, w_a, w_b, w_t, w_brev, w_cnt_nx;
  logic signed [DATA_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
  logic                     w_clip;

  genvar gi;
  for (gi = 0; gi < POINTS; gi++) begin : g_tw
    localparam tw_t FWD = twiddle(gi, POINTS, 1'b0, TW_W);
    localparam tw_t INV = twiddle(gi, POINTS, 1'b1, TW_W);
    assign w_rom_re[gi] = r_mode ? TW_W'(INV.re) : TW_W'(FWD.re);
    assign w_rom_im[gi] = r_mode ? TW_W'(INV.im) : TW_W'(FWD.im);
  end

  // Butterfly j of stage s: a inserts a zero bit at position s of j, b sets it.
  assign w_j      = LOG2N'(r_bf);
  assign w_mask   = (LOG2N'(1) << r_stage) - LOG2N'(1);
  assign w_a      = ((w_j >> r_stage) << (r_stage + STW'(1))) | (w_j & w_mask);
  assign w_b      = w_a | (LOG2N'(1) << r_stage);
  assign w_t      = (w_j & w_mask) << (LOG2N - 1 - int'(r_stage));
  assign w_brev   = LOG2N'(bitrev(int'(r_cnt), LOG2N));
  assign w_cnt_nx = r_cnt + 1'b1;

  fft_radix2_bfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bfly (
    .i_a_re    (r_mem_re[w_a]),
    .i_a_im    (r_mem_im[w_a]),
    .i_b_re    (r_mem_re[w_b]),
    .i_b_im    (r_mem_im[w_b]),
    .i_w_re    (w_rom_re[w_t]),
    .i_w_im    (w_rom_im[w_t]),
    .i_inverse (r_mode),
    .o_a_re    (w_a_re),
    .o_a_im    (w_a_im),
    .o_b_re    (w_b_re),
    .o_b_im    (w_b_im),
    .o_clip    (w_clip)
  );

  always_ff @(posedge clk) begin
    if (r_state == LOAD && s_valid) begin
      r_mem_re[w_brev] <= s_re;
      r_mem_im[w_brev] <= s_im;
    end else if (r_state == COMPUTE) begin
      r_mem_re[w_a] <= w_a_re;
      r_mem_im[w_a] <= w_a_im;
      r_mem_re[w_b] <= w_b_re;
      r_mem_im[w_b] <= w_b_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_cnt     <= '0;
      r_stage   <= '0;
      r_bf      <= '0;
      r_mode    <= 1'b0;
      r_ovf     <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_re    <= '0;
      r_m_im    <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (s_valid) begin
            if (r_cnt == '0) begin
              r_mode <= inverse;
              r_ovf  <= 1'b0;
            end
            if (r_cnt == LOG2N'(POINTS - 1)) begin
              r_cnt   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_cnt <= w_cnt_nx;
            end
          end
        end
        COMPUTE: begin
          if (w_clip) r_ovf <= 1'b1;
          if (r_bf == BFW'(POINTS / 2 - 1)) begin
            r_bf <= '0;
            if (r_stage == STW'(LOG2N - 1)) begin
              r_stage <= '0;
              r_state <= UNLOAD;
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end else begin
            r_bf <= r_bf + 1'b1;
          end
        end
        UNLOAD: begin
          // r_cnt always names the bin currently held in the output register.
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
            r_m_re    <= r_mem_re[r_cnt];
            r_m_im    <= r_mem_im[r_cnt];
            r_m_last  <= (r_cnt == LOG2N'(POINTS - 1));
          end else if (m_ready) begin
            if (r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_cnt     <= '0;
              r_state   <= LOAD;
            end else begin
              r_cnt    <= w_cnt_nx;
              r_m_re   <= r_mem_re[w_cnt_nx];
              r_m_im   <= r_mem_im[w_cnt_nx];
              r_m_last <= (w_cnt_nx == LOG2N'(POINTS - 1));
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s_ready = (r_state == LOAD);
  assign busy    = (r_state != LOAD);
  assign m_valid = r_m_valid;
  assign m_re    = r_m_re;
  assign m_im    = r_m_im;
  assign m_last  = r_m_last;
  assign ovf     = r_ovf;

endmodule
